// File: rtl/serial_adder_ctrl_if.sv
// Handshake and data bundle between the ALU front-end and the serial adder sequencer.
// The front-end (master) drives the request and operands; the sequencer (slave)
// returns status and the registered result.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             op_sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, op_sub, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, op_sub, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder/subtractor sequencer: runs one full-adder slice over WIDTH-bit
// operands, LSB first, one bit per clock, and presents registered sum, carry out
// and signed overflow with a one-cycle done pulse.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_adder_ctrl_if.slave bus
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] MSB_M1   = CW'(WIDTH - 2);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             c_msb_in;

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic             fa_s;
    logic             fa_c;
    logic             accept;
    logic             last_bit;

    // A new request is taken whenever no bits are in flight (IDLE or DONE).
    assign accept   = (state != RUN) && bus.start;
    assign last_bit = (state == RUN) && (cnt == LAST_BIT);

    // The shared full-adder slice operating on the current LSBs and running carry.
    always_comb begin
        fa_s = a_sh[0] ^ b_sh[0] ^ carry;
        fa_c = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: DONE behaves like IDLE for accepting back-to-back requests.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = bus.start ? RUN : IDLE;
            RUN:     next_state = (cnt == LAST_BIT) ? DONE : RUN;
            DONE:    next_state = bus.start ? RUN : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Status and result outputs decoded from the state and result registers.
    always_comb begin
        bus.busy = (state == RUN);
        bus.done = (state == DONE);
        bus.sum  = sum_q;
        bus.cout = cout_q;
        bus.ovf  = ovf_q;
    end

    // Operand shifters, running carry and bit counter; subtraction is A + ~B + 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            s_sh     <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            c_msb_in <= 1'b0;
        end else if (accept) begin
            a_sh  <= bus.a;
            b_sh  <= bus.op_sub ? ~bus.b : bus.b;
            carry <= bus.op_sub ? 1'b1 : bus.cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            s_sh  <= {fa_s, s_sh[WIDTH-1:1]};
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            carry <= fa_c;
            cnt   <= cnt + CW'(1);
            // The carry produced by bit WIDTH-2 is the carry into the MSB.
            if (cnt == MSB_M1) begin
                c_msb_in <= fa_c;
            end
        end
    end

    // Result registers only change on the final bit, so they hold through RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (last_bit) begin
            sum_q  <= {fa_s, s_sh[WIDTH-1:1]};
            cout_q <= fa_c;
            ovf_q  <= c_msb_in ^ fa_c;
        end
    end

endmodule
